// File: rtl/dpram_port_arbiter_pkg.sv
// Shared helpers for the dual-port RAM port arbiter.
package dpram_port_arbiter_pkg;

  // Number of bits needed to hold 'value' (at least 1).
  function automatic int bit_fit(input int value);
    int w;
    w = 1;
    while ((value >> w) != 0) w++;
    return w;
  endfunction

endpackage

// File: rtl/dpram_port_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the side not granted last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       id
);

  always_comb begin
    valid = |req;
    id    = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between two requesters, with burst capping
// and ID-tagged read return aligned to the RAM's one-cycle registered read data.
module dpram_port_arbiter
  import dpram_port_arbiter_pkg::*;
#(
  parameter  int DBW       = 32,
  parameter  int DEPTH     = 1024,
  parameter  int MAX_BURST = 8,
  localparam int ABW       = bit_fit(DEPTH - 1)
) (
  input  logic           iCLK,
  input  logic           iRST,
  input  logic           iR0_REQ,
  input  logic           iR0_WR,
  input  logic [ABW-1:0] iR0_ADDR,
  input  logic [DBW-1:0] iR0_WDATA,
  output logic           oR0_ACK,
  input  logic           iR1_REQ,
  input  logic           iR1_WR,
  input  logic [ABW-1:0] iR1_ADDR,
  input  logic [DBW-1:0] iR1_WDATA,
  output logic           oR1_ACK,
  output logic [ABW-1:0] oRAM_ADDR,
  output logic           oRAM_WR,
  output logic [DBW-1:0] oRAM_WDATA,
  input  logic [DBW-1:0] iRAM_RDATA,
  output logic           oRD_VALID,
  output logic           oRD_ID,
  output logic [DBW-1:0] oRD_DATA,
  output logic           oBUSY,
  output logic [1:0]     oDBG_STATE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  localparam int           CW       = bit_fit(MAX_BURST);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_id_q, rd_id_d;

  logic       acc0, acc1, own_req;
  logic [1:0] pick_req;
  logic       pick_valid, pick_id;

  // In a grant state the owner is masked out, so the picker only reports the other side.
  always_comb begin
    acc0    = (state_q == GNT0) && iR0_REQ;
    acc1    = (state_q == GNT1) && iR1_REQ;
    own_req = (state_q == GNT1) ? iR1_REQ : iR0_REQ;
    case (state_q)
      IDLE:    pick_req = {iR1_REQ, iR0_REQ};
      GNT0:    pick_req = {iR1_REQ, 1'b0};
      GNT1:    pick_req = {1'b0, iR0_REQ};
      default: pick_req = 2'b00;
    endcase
  end

  rr_pick2 u_pick (
    .req   (pick_req),
    .last  (last_q),
    .valid (pick_valid),
    .id    (pick_id)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    rd_pend_d = (acc0 && !iR0_WR) || (acc1 && !iR1_WR);
    rd_id_d   = acc1 ? 1'b1 : (acc0 ? 1'b0 : rd_id_q);
    case (state_q)
      IDLE: begin
        if (pick_valid) state_d = pick_id ? GNT1 : GNT0;
      end
      GNT0, GNT1: begin
        if (own_req) begin
          last_d = (state_q == GNT1);
          cnt_d  = cnt_q + CW'(1);
        end
        // End of a burst or a dropped request hands over without an idle bubble.
        if (!own_req || cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (pick_valid)    state_d = pick_id ? GNT1 : GNT0;
          else if (!own_req) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_id_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
    end
  end

  always_comb begin
    case (state_q)
      GNT0: begin
        oRAM_ADDR  = iR0_ADDR;
        oRAM_WR    = iR0_WR && iR0_REQ;
        oRAM_WDATA = iR0_WDATA;
      end
      GNT1: begin
        oRAM_ADDR  = iR1_ADDR;
        oRAM_WR    = iR1_WR && iR1_REQ;
        oRAM_WDATA = iR1_WDATA;
      end
      default: begin
        oRAM_ADDR  = '0;
        oRAM_WR    = 1'b0;
        oRAM_WDATA = '0;
      end
    endcase
  end

  assign oR0_ACK    = acc0;
  assign oR1_ACK    = acc1;
  assign oRD_VALID  = rd_pend_q;
  assign oRD_ID     = rd_id_q;
  assign oRD_DATA   = iRAM_RDATA;
  assign oBUSY      = (state_q != IDLE);
  assign oDBG_STATE = state_q;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed and random bench for dpram_port_arbiter with a behavioural RAM and read scoreboard.
module tb_dpram_port_arbiter;

  localparam int DBW = 32;
  localparam int ABW = 10;

  logic           clk, rst;
  logic           r0_req, r0_wr, r1_req, r1_wr;
  logic [ABW-1:0] r0_addr, r1_addr;
  logic [DBW-1:0] r0_wdata, r1_wdata;
  logic           ack0, ack1;
  logic [ABW-1:0] ram_addr;
  logic           ram_wr;
  logic [DBW-1:0] ram_wdata, ram_rdata;
  logic           rd_valid, rd_id;
  logic [DBW-1:0] rd_data;
  logic           busy;
  logic [1:0]     dbg_state;

  logic [DBW-1:0] mem   [0:(1<<ABW)-1];
  logic [DBW-1:0] model [0:(1<<ABW)-1];
  logic [DBW:0]   exp_q [$];

  int n_cmp = 0;
  int n_bad = 0;

  dpram_port_arbiter dut (
    .iCLK(clk), .iRST(rst),
    .iR0_REQ(r0_req), .iR0_WR(r0_wr), .iR0_ADDR(r0_addr), .iR0_WDATA(r0_wdata), .oR0_ACK(ack0),
    .iR1_REQ(r1_req), .iR1_WR(r1_wr), .iR1_ADDR(r1_addr), .iR1_WDATA(r1_wdata), .oR1_ACK(ack1),
    .oRAM_ADDR(ram_addr), .oRAM_WR(ram_wr), .oRAM_WDATA(ram_wdata), .iRAM_RDATA(ram_rdata),
    .oRD_VALID(rd_valid), .oRD_ID(rd_id), .oRD_DATA(rd_data), .oBUSY(busy), .oDBG_STATE(dbg_state)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < (1<<ABW); i++) begin
      mem[i]   = '0;
      model[i] = '0;
    end
  end

  // Behavioural RAM port with registered read data
  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_all();
    r0_req = 0; r0_wr = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_wr = 0; r1_addr = '0; r1_wdata = '0;
  endtask

  // Scoreboard: retire the returning read first, then record this cycle's accepted beats
  always @(negedge clk) begin
    logic [DBW:0] e;
    if (rd_valid) begin
      if (exp_q.size() == 0) chk("rd_spurious", rd_valid, 0);
      else begin
        e = exp_q.pop_front();
        chk("rd_id_data", {rd_id, rd_data}, e);
      end
    end
    if (rst) exp_q.delete();
    chk("ack_onehot", ack0 & ack1, 0);
    if (ack0) begin
      if (r0_wr) model[r0_addr] = r0_wdata;
      else if (!rst) exp_q.push_back({1'b0, model[r0_addr]});
    end
    if (ack1) begin
      if (r1_wr) model[r1_addr] = r1_wdata;
      else if (!rst) exp_q.push_back({1'b1, model[r1_addr]});
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned seg_who [8] = '{2, 0, 1, 0, 1, 2, 0, 2};
    int unsigned seg_len [8] = '{1, 8, 8, 8, 4, 1, 4, 1};
    int rem0, rem1, c;
    logic [1:0] exp_ack;
    logic a0, a1;

    // Test 1: reset state, write then read addr 5
    rst = 1; idle_all();
    cyc(); cyc();
    mid();
    chk("rst_busy", busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_id", rd_id, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wr", ram_wr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_ack0", ack0, 0);
    chk("rst_state", dbg_state, 0);
    cyc();
    rst = 0;
    r0_req = 1; r0_wr = 1; r0_addr = 10'd5; r0_wdata = 32'hA5A5A5A5;
    mid(); chk("t1_ack_latency", ack0, 0);
    cyc();
    mid();
    chk("t1_wr_ack", ack0, 1);
    chk("t1_ram_wr", ram_wr, 1);
    chk("t1_ram_addr", ram_addr, 5);
    chk("t1_ram_wdata", ram_wdata, 32'hA5A5A5A5);
    cyc();
    r0_wr = 0;
    mid();
    chk("t1_rd_ack", ack0, 1);
    chk("t1_rd_ram_wr", ram_wr, 0);
    cyc();
    r0_req = 0;
    mid();
    chk("t1_rd_valid", rd_valid, 1);
    chk("t1_rd_id", rd_id, 0);
    chk("t1_rd_data", rd_data, 32'hA5A5A5A5);
    cyc();
    mid(); chk("t1_idle", busy, 0);
    cyc();

    // Test 2: tie right after reset goes to R0, then R1 without a bubble
    rst = 1;
    cyc();
    rst = 0;
    r0_req = 1; r0_wr = 0; r0_addr = 10'd5;
    r1_req = 1; r1_wr = 0; r1_addr = 10'd6;
    mid();
    chk("t2_idle_ack0", ack0, 0);
    chk("t2_idle_ack1", ack1, 0);
    cyc();
    mid();
    chk("t2_first_ack0", ack0, 1);
    chk("t2_first_ack1", ack1, 0);
    cyc();
    r0_req = 0;
    mid();
    chk("t2_drop_acks", {ack1, ack0}, 2'b00);
    cyc();
    mid();
    chk("t2_r1_ack", ack1, 1);
    chk("t2_r1_busy", busy, 1);
    cyc();
    r1_req = 0;
    cyc();
    mid(); chk("t2_idle", busy, 0);
    cyc();

    // Test 3: R0 streams 20 reads, R1 joins from cycle 3 with 12 reads
    rem0 = 20; rem1 = 12; c = 0;
    for (int s = 0; s < 8; s++) begin
      for (int k = 0; k < int'(seg_len[s]); k++) begin
        r0_req = (rem0 > 0); r0_wr = 0; r0_addr = ABW'(rem0);
        r1_req = (c >= 3) && (rem1 > 0); r1_wr = 0; r1_addr = ABW'(200 + rem1);
        exp_ack = (seg_who[s] == 0) ? 2'b01 : ((seg_who[s] == 1) ? 2'b10 : 2'b00);
        mid();
        chk($sformatf("t3_ack_c%0d", c), {ack1, ack0}, exp_ack);
        if (ack0) rem0--;
        if (ack1) rem1--;
        cyc();
        c++;
      end
    end
    chk("t3_all_beats", {rem1[7:0], rem0[7:0]}, 16'h0000);

    // Test 4: R1 alone streams 20 writes across the counter rollover
    rem1 = 20;
    for (int i = 0; i < 21; i++) begin
      r1_req = (rem1 > 0); r1_wr = 1; r1_addr = ABW'(300 + rem1); r1_wdata = $urandom;
      mid();
      chk($sformatf("t4_ack_%0d", i), ack1, (i >= 1));
      chk($sformatf("t4_busy_%0d", i), busy, (i >= 1));
      if (ack1) rem1--;
      cyc();
    end
    r1_req = 0;
    cyc();
    mid(); chk("t4_idle", busy, 0);
    cyc();

    // Test 5: reset in the cycle after a read ACK, mid-burst
    r0_req = 1; r0_wr = 0; r0_addr = 10'd7;
    mid(); chk("t5_lat", ack0, 0);
    cyc();
    mid(); chk("t5_ack_a", ack0, 1);
    cyc();
    mid(); chk("t5_ack_b", ack0, 1);
    cyc();
    rst = 1;
    mid(); chk("t5_rdv_in_rst", rd_valid, 1);
    cyc();
    rst = 0;
    r1_req = 1; r1_wr = 0; r1_addr = 10'd8;
    mid();
    chk("t5_rdv_after", rd_valid, 0);
    chk("t5_busy_after", busy, 0);
    chk("t5_state_after", dbg_state, 0);
    chk("t5_no_ack", {ack1, ack0}, 2'b00);
    cyc();
    mid(); chk("t5_tie_r0", {ack1, ack0}, 2'b01);
    cyc();
    idle_all();
    cyc(); cyc();

    // Test 6: random traffic on both sides
    a0 = 0; a1 = 0;
    for (int i = 0; i < 10000; i++) begin
      if (!r0_req || a0) begin
        r0_req = ($urandom_range(0, 3) != 0); r0_wr = $urandom_range(0, 1);
        r0_addr = ABW'($urandom_range(0, 15)); r0_wdata = $urandom;
      end
      if (!r1_req || a1) begin
        r1_req = ($urandom_range(0, 3) != 0); r1_wr = $urandom_range(0, 1);
        r1_addr = ABW'($urandom_range(0, 15)); r1_wdata = $urandom;
      end
      mid();
      a0 = ack0; a1 = ack1;
      cyc();
    end
    idle_all();
    repeat (4) cyc();
    chk("sb_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
